data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 149 ++++++++++++++
 tb/tb_data_mem_responder.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed 32-bit data memory slave with a fixed wait-state count
// and a four-phase Ready handshake.
//
// Parameters:
//   ADDR_BITS - implemented word-address bits (2^ADDR_BITS x 32-bit words)
//   LATENCY   - wait cycles between request acceptance and Ready (0..15)
//
// Ports:
//   clock           in   clock, rising edge
//   reset           in   asynchronous active-low reset
//   DataMem_Read    in   read request
//   DataMem_Write   in   byte-lane write strobes, bit i -> data[8i+7:8i]
//   DataMem_Address in   word address
//   DataMem_Out     in   write data
//   DataMem_In      out  read data (word after any write), held while Ready=1
//   DataMem_Ready   out  transaction complete, registered
//   DataMem_Error   out  out-of-range address flag, only with DATAMEM_RANGE_CHECK_EN defined
//
// Optional feature macro: DATAMEM_RANGE_CHECK_EN
//   When defined, addresses with bits set above ADDR_BITS-1 do not write storage and
//   return 32'hDEADBEEF with DataMem_Error=1. When undefined, addresses wrap.

module data_mem_responder #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        DataMem_Read,
    input  logic [3:0]  DataMem_Write,
    input  logic [29:0] DataMem_Address,
    input  logic [31:0] DataMem_Out,
    output logic [31:0] DataMem_In,
    output logic        DataMem_Ready
`ifdef DATAMEM_RANGE_CHECK_EN
    ,
    output logic        DataMem_Error
`endif
);

    localparam int unsigned Depth = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e                 state_q;
    logic [3:0]             cnt_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [3:0]             wstrb_q;
    logic [31:0]            wdata_q;
    logic                   ready_q;
    logic [31:0]            rdata_q;
    logic                   err_q;
    logic                   oor_q;

    logic [31:0]            mem_q [Depth];

    logic                   req_valid;
    logic                   oor_now;
    logic                   oor;
    logic                   finish;
    logic                   mem_we;
    logic [31:0]            cur_word;
    logic [31:0]            merged;

    assign req_valid = DataMem_Read | (|DataMem_Write);

`ifdef DATAMEM_RANGE_CHECK_EN
    assign oor_now       = (DataMem_Address >> ADDR_BITS) != 30'd0;
    assign oor           = oor_q;
    assign DataMem_Error = err_q;
`else
    // Upper address bits are intentionally ignored: addresses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^(DataMem_Address >> ADDR_BITS) ^ oor_q ^ err_q;
    assign oor_now        = 1'b0;
    assign oor            = 1'b0;
`endif

    assign finish   = (state_q == StBusy) && (cnt_q == 4'd0);
    assign mem_we   = finish && (|wstrb_q) && !oor;
    assign cur_word = mem_q[addr_q];

    // Byte-masked merge of latched write data over the stored word.
    always_comb begin
        merged = cur_word;
        for (int i = 0; i < 4; i++) begin
            if (wstrb_q[i]) begin
                merged[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wstrb_q <= 4'd0;
            wdata_q <= 32'd0;
            oor_q   <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        addr_q  <= DataMem_Address[ADDR_BITS-1:0];
                        wstrb_q <= DataMem_Write;
                        wdata_q <= DataMem_Out;
                        oor_q   <= oor_now;
                        cnt_q   <= 4'(LATENCY);
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StDone;
                        ready_q <= 1'b1;
                        err_q   <= oor;
                        rdata_q <= oor ? 32'hDEAD_BEEF : merged;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StDone: begin
                    // Hold Ready and data until the requester withdraws.
                    if (!req_valid) begin
                        state_q <= StIdle;
                        ready_q <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Storage has no reset; it is written only on the BUSY->DONE edge.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[addr_q] <= merged;
        end
    end

    assign DataMem_In    = rdata_q;
    assign DataMem_Ready = ready_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam int unsigned Lat = 2;

    logic        clock;
    logic        reset;
    logic        DataMem_Read;
    logic [3:0]  DataMem_Write;
    logic [29:0] DataMem_Address;
    logic [31:0] DataMem_Out;
    logic [31:0] DataMem_In;
    logic        DataMem_Ready;
    logic        DataMem_Error;

    int checks = 0;
    int errors = 0;

    data_mem_responder #(
        .ADDR_BITS(8),
        .LATENCY  (Lat)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .DataMem_Read   (DataMem_Read),
        .DataMem_Write  (DataMem_Write),
        .DataMem_Address(DataMem_Address),
        .DataMem_Out    (DataMem_Out),
        .DataMem_In     (DataMem_In),
        .DataMem_Ready  (DataMem_Ready)
`ifdef DATAMEM_RANGE_CHECK_EN
        ,
        .DataMem_Error  (DataMem_Error)
`endif
    );

`ifndef DATAMEM_RANGE_CHECK_EN
    assign DataMem_Error = 1'b0;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full four-phase transaction; inputs change on negedges, outputs sampled on negedges.
    task automatic xact(input string tag, input logic rd, input logic [3:0] wr,
                        input logic [29:0] addr, input logic [31:0] data,
                        input logic [31:0] exp, input logic exp_err, input logic scramble);
        @(negedge clock);
        DataMem_Read    = rd;
        DataMem_Write   = wr;
        DataMem_Address = addr;
        DataMem_Out     = data;
        // Negedges after acceptance edge k .. k+Lat: still waiting.
        for (int i = 0; i <= int'(Lat); i++) begin
            @(negedge clock);
            check({tag, " ready_wait"}, {31'd0, DataMem_Ready}, 32'd0);
            if (scramble && i == 0) begin
                DataMem_Address = 30'd9;
                DataMem_Out     = 32'hFFFF_FFFF;
                DataMem_Write   = 4'hF;
            end
        end
        @(negedge clock);
        check({tag, " ready_rise"}, {31'd0, DataMem_Ready}, 32'd1);
        check({tag, " data"}, DataMem_In, exp);
        check({tag, " error"}, {31'd0, DataMem_Error}, {31'd0, exp_err});
        @(negedge clock);
        check({tag, " ready_hold"}, {31'd0, DataMem_Ready}, 32'd1);
        check({tag, " data_hold"}, DataMem_In, exp);
        DataMem_Read  = 1'b0;
        DataMem_Write = 4'h0;
        @(negedge clock);
        check({tag, " ready_fall"}, {31'd0, DataMem_Ready}, 32'd0);
        check({tag, " error_fall"}, {31'd0, DataMem_Error}, 32'd0);
    endtask

    initial begin
        DataMem_Read    = 1'b0;
        DataMem_Write   = 4'h0;
        DataMem_Address = 30'd0;
        DataMem_Out     = 32'd0;
        reset           = 1'b0;
        #1;
        check("reset_ready", {31'd0, DataMem_Ready}, 32'd0);
        check("reset_in", DataMem_In, 32'd0);
        check("reset_err", {31'd0, DataMem_Error}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // Full-word write, then read back.
        xact("wr5", 1'b0, 4'hF, 30'd5, 32'hA5A5_0001, 32'hA5A5_0001, 1'b0, 1'b0);
        xact("rd5", 1'b1, 4'h0, 30'd5, 32'h0, 32'hA5A5_0001, 1'b0, 1'b0);

        // Single byte-lane write merges with stored word.
        xact("wr5_b1", 1'b0, 4'b0010, 30'd5, 32'h0000_CC00, 32'hA5A5_CC01, 1'b0, 1'b0);
        xact("rd5_b1", 1'b1, 4'h0, 30'd5, 32'h0, 32'hA5A5_CC01, 1'b0, 1'b0);

        // Read+write together: write lane 3 first, return merged word.
        xact("rw5", 1'b1, 4'b1000, 30'd5, 32'h5A00_0000, 32'h5AA5_CC01, 1'b0, 1'b0);

        // Inputs changed during BUSY are ignored.
        xact("wr9", 1'b0, 4'hF, 30'd9, 32'h9999_0000, 32'h9999_0000, 1'b0, 1'b0);
        xact("wr6_scr", 1'b0, 4'hF, 30'd6, 32'h1111_2222, 32'h1111_2222, 1'b0, 1'b1);
        xact("rd6", 1'b1, 4'h0, 30'd6, 32'h0, 32'h1111_2222, 1'b0, 1'b0);
        xact("rd9", 1'b1, 4'h0, 30'd9, 32'h0, 32'h9999_0000, 1'b0, 1'b0);

        // Reset mid-BUSY aborts the write to addr 7.
        xact("wr7", 1'b0, 4'hF, 30'd7, 32'h7777_0007, 32'h7777_0007, 1'b0, 1'b0);
        @(negedge clock);
        DataMem_Write   = 4'hF;
        DataMem_Address = 30'd7;
        DataMem_Out     = 32'hBAD0_0BAD;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("abort_ready", {31'd0, DataMem_Ready}, 32'd0);
        check("abort_in", DataMem_In, 32'd0);
        DataMem_Write = 4'h0;
        @(negedge clock);
        reset = 1'b1;
        xact("rd7", 1'b1, 4'h0, 30'd7, 32'h0, 32'h7777_0007, 1'b0, 1'b0);

        // Address above the implemented range.
        xact("wr0", 1'b0, 4'hF, 30'd0, 32'h00C0_FFEE, 32'h00C0_FFEE, 1'b0, 1'b0);
`ifdef DATAMEM_RANGE_CHECK_EN
        xact("rd100", 1'b1, 4'h0, 30'h100, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b0);
        xact("wr105", 1'b0, 4'hF, 30'h105, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 1'b0);
        xact("rd5_kept", 1'b1, 4'h0, 30'd5, 32'h0, 32'h5AA5_CC01, 1'b0, 1'b0);
`else
        xact("rd100", 1'b1, 4'h0, 30'h100, 32'h0, 32'h00C0_FFEE, 1'b0, 1'b0);
        xact("wr105", 1'b0, 4'b0001, 30'h105, 32'h0000_0042, 32'h5AA5_CC42, 1'b0, 1'b0);
        xact("rd5_wrap", 1'b1, 4'h0, 30'd5, 32'h0, 32'h5AA5_CC42, 1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
